// File: rtl/pifo_sched_pkg.sv
// rtl/pifo_sched_pkg.sv - shared constants, element fields and FSM states for the root PIFO access controller
package pifo_sched_pkg;

    localparam int PIFO_ROOT_WIDTH           = 32;
    localparam int PIFO_CALENDAR_SIZE        = 1024;
    localparam int PIFO_CALENDAR_INDEX_WIDTH = 10;
    localparam int BUFFER_ADDR_WIDTH         = 12;
    localparam int ROOT_PIFO_INFO_VALID_POS  = 31;
    localparam int STARVE_LIMIT              = 8;

    // Rank occupies the bits between the buffer address and the valid flag.
    localparam int RANK_LSB = BUFFER_ADDR_WIDTH;
    localparam int RANK_MSB = ROOT_PIFO_INFO_VALID_POS - 1;

    // Two entries of headroom are kept free in the calendar.
    localparam logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] FULL_LEVEL =
        PIFO_CALENDAR_INDEX_WIDTH'(PIFO_CALENDAR_SIZE - 2);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_CPU_ISSUE = 2'd1,
        S_CPU_WAIT  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/pifo_calendar_sched_ctrl_if.sv
// rtl/pifo_calendar_sched_ctrl_if.sv - upstream enqueue, dequeue and CPU write channels of the PIFO controller
interface pifo_calendar_sched_ctrl_if;
    import pifo_sched_pkg::*;

    logic [PIFO_ROOT_WIDTH-1:0]           s_axis_enq_tdata;
    logic                                 s_axis_enq_tvalid;
    logic                                 s_axis_enq_tready;
    logic                                 s_deq_req_valid;
    logic                                 s_deq_req_ready;
    logic [BUFFER_ADDR_WIDTH-1:0]         m_axis_deq_tdata;
    logic                                 m_axis_deq_tvalid;
    logic                                 m_axis_deq_tready;
    logic                                 cpu_wr_valid;
    logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_wr_addr;
    logic [PIFO_ROOT_WIDTH-1:0]           cpu_wr_data;
    logic                                 cpu_wr_done;

    modport master (
        output s_axis_enq_tdata, s_axis_enq_tvalid, s_deq_req_valid, m_axis_deq_tready,
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        input  s_axis_enq_tready, s_deq_req_ready, m_axis_deq_tdata, m_axis_deq_tvalid, cpu_wr_done
    );

    modport slave (
        input  s_axis_enq_tdata, s_axis_enq_tvalid, s_deq_req_valid, m_axis_deq_tready,
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        output s_axis_enq_tready, s_deq_req_ready, m_axis_deq_tdata, m_axis_deq_tvalid, cpu_wr_done
    );

endinterface

// File: rtl/pifo_calendar_sched_ctrl.sv
// rtl/pifo_calendar_sched_ctrl.sv - root PIFO calendar access arbiter; optional PIFO_CTRL_STARVE_GUARD_EN enqueue starvation guard
module pifo_calendar_sched_ctrl
    import pifo_sched_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rstn,
    pifo_calendar_sched_ctrl_if.slave            up,
    output logic [PIFO_ROOT_WIDTH-1:0]           cal_pifo_info_root,
    output logic                                 cal_insert_en,
    output logic                                 cal_pop_en,
    output logic                                 cal_cpu_wr_valid,
    output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cal_cpu_wr_addr,
    output logic [PIFO_ROOT_WIDTH-1:0]           cal_cpu_wr_data,
    input  logic                                 cal_cpu_wr_result_valid,
    input  logic [PIFO_ROOT_WIDTH-1:0]           cal_top,
    output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] occupancy,
    output logic                                 empty,
    output logic                                 full
);

    sched_state_e                 state;
    logic                         cpu_pend;
    logic [BUFFER_ADDR_WIDTH-1:0] deq_tdata_q;
    logic                         deq_tvalid_q;
    logic                         slot_free, run, enq_ok, pop_ok, force_enq;
    logic                         pop_grant, enq_grant;
    logic                         unused_top;

    assign unused_top = ^cal_top[PIFO_ROOT_WIDTH-1:BUFFER_ADDR_WIDTH];

    assign empty     = (occupancy == '0);
    assign full      = (occupancy == FULL_LEVEL);
    assign run       = (state == S_RUN);
    assign slot_free = ~deq_tvalid_q | up.m_axis_deq_tready;
    assign enq_ok    = up.s_axis_enq_tvalid & ~full;
    assign pop_ok    = up.s_deq_req_valid & ~empty & slot_free;

`ifdef PIFO_CTRL_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_cnt;

    assign force_enq = (starve_cnt >= STARVE_MAX);

    // Counts consecutive arbitrations an eligible enqueue lost to a pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            starve_cnt <= '0;
        else if (enq_grant)
            starve_cnt <= '0;
        else if (enq_ok && pop_grant)
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign force_enq = 1'b0;
`endif

    assign pop_grant = run & pop_ok & ~(force_enq & enq_ok);
    assign enq_grant = run & enq_ok & ~pop_grant;

    // Elements with a clear valid bit are accepted but never reach the calendar.
    assign cal_insert_en      = enq_grant & up.s_axis_enq_tdata[ROOT_PIFO_INFO_VALID_POS];
    assign cal_pop_en         = pop_grant;
    assign cal_pifo_info_root = cal_insert_en ? up.s_axis_enq_tdata : '0;

    assign up.s_axis_enq_tready = enq_grant;
    assign up.s_deq_req_ready   = pop_grant;
    assign up.m_axis_deq_tdata  = deq_tdata_q;
    assign up.m_axis_deq_tvalid = deq_tvalid_q;
    assign up.cpu_wr_done       = (state == S_CPU_WAIT) & cal_cpu_wr_result_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            occupancy <= '0;
        else if (cal_insert_en && !full)
            occupancy <= occupancy + 1'b1;
        else if (cal_pop_en && !empty)
            occupancy <= occupancy - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            deq_tdata_q  <= '0;
            deq_tvalid_q <= 1'b0;
        end else if (pop_grant) begin
            deq_tdata_q  <= cal_top[BUFFER_ADDR_WIDTH-1:0];
            deq_tvalid_q <= 1'b1;
        end else if (up.m_axis_deq_tready) begin
            deq_tvalid_q <= 1'b0;
        end
    end

    // The CPU register doubles as the calendar write fields; it only reloads when idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= S_RUN;
            cpu_pend         <= 1'b0;
            cal_cpu_wr_valid <= 1'b0;
            cal_cpu_wr_addr  <= '0;
            cal_cpu_wr_data  <= '0;
        end else begin
            cal_cpu_wr_valid <= 1'b0;
            if (up.cpu_wr_valid && !cpu_pend) begin
                cpu_pend        <= 1'b1;
                cal_cpu_wr_addr <= up.cpu_wr_addr;
                cal_cpu_wr_data <= up.cpu_wr_data;
            end
            case (state)
                S_RUN: begin
                    if (cpu_pend || up.cpu_wr_valid) begin
                        state            <= S_CPU_ISSUE;
                        cal_cpu_wr_valid <= 1'b1;
                    end
                end
                S_CPU_ISSUE: state <= S_CPU_WAIT;
                S_CPU_WAIT: begin
                    if (cal_cpu_wr_result_valid) begin
                        state    <= S_RUN;
                        cpu_pend <= 1'b0;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule
